nd_stream_arbiter: RTL and testbench



---
 rtl/nd_stream_arbiter_pkg.sv | 30 +++
 rtl/nd_fifo.sv | 56 +++++
 rtl/nd_stream_arbiter.sv | 102 ++++++++++
 tb/tb_nd_stream_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/nd_stream_arbiter_pkg.sv
// Shared definitions for the nd-stream arbiter: source-index width, reset
// value of the round-robin pointer and the pop-select helper.
package nd_stream_arbiter_pkg;

  localparam int SRC_W = 1;
  // Reset to 1 so that source 0 wins the first tie.
  localparam logic [SRC_W-1:0] LAST_RST = 1'b1;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_0    = 2'd1,
    SEL_1    = 2'd2
  } sel_e;

  // Round-robin choice from registered FIFO occupancy and the previous winner.
  function automatic sel_e pick_source(input logic has0, input logic has1,
                                       input logic [SRC_W-1:0] last);
    sel_e sel;
    sel = SEL_NONE;
    if (has0 && has1) begin
      sel = (last == 1'b1) ? SEL_0 : SEL_1;
    end else if (has0) begin
      sel = SEL_0;
    end else if (has1) begin
      sel = SEL_1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/nd_fifo.sv
// Small synchronous FIFO for nd streams: head entry readable combinationally,
// a write into a full FIFO is accepted when the same cycle also pops it.
module nd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rptr];

  // When full, wptr == rptr: the head is read this cycle before the slot is
  // overwritten by the non-blocking write, so push+pop at full is safe.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nd_stream_arbiter.sv
// Two-source round-robin arbiter merging nd streams into one tagged nd stream;
// each source is buffered in its own FIFO and overflow sets a sticky error.
//
// nd semantics: a word is transferred in every cycle its nd strobe is high;
// there is no ready/backpressure in either direction, so the consumer must
// accept every out_nd word and a producer word that finds its FIFO full
// (and not popped that cycle) is dropped.
module nd_stream_arbiter
  import nd_stream_arbiter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MWIDTH = 1,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in0_data,
  input  logic              in0_nd,
  input  logic [MWIDTH-1:0] in0_m,
  input  logic [WIDTH-1:0]  in1_data,
  input  logic              in1_nd,
  input  logic [MWIDTH-1:0] in1_m,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_nd,
  output logic [MWIDTH-1:0] out_m,
  output logic              out_src,
  output logic              error
);

  localparam int FW = WIDTH + MWIDTH;

  logic [FW-1:0]    head0;
  logic [FW-1:0]    head1;
  logic             empty0;
  logic             empty1;
  logic             full0;
  logic             full1;
  logic             pop0;
  logic             pop1;
  logic             drop0;
  logic             drop1;
  logic [SRC_W-1:0] last;
  sel_e             sel;

  nd_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in0_nd),
    .wr_data ({in0_m, in0_data}),
    .rd_en   (pop0),
    .rd_data (head0),
    .empty   (empty0),
    .full    (full0)
  );

  nd_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in1_nd),
    .wr_data ({in1_m, in1_data}),
    .rd_en   (pop1),
    .rd_data (head1),
    .empty   (empty1),
    .full    (full1)
  );

  always_comb begin
    sel  = pick_source(!empty0, !empty1, last);
    pop0 = (sel == SEL_0);
    pop1 = (sel == SEL_1);
  end

  // Mirrors the FIFO acceptance rule: full and not popped means dropped.
  assign drop0 = in0_nd && full0 && !pop0;
  assign drop1 = in1_nd && full1 && !pop1;

  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= LAST_RST;
      out_data <= '0;
      out_m    <= '0;
      out_src  <= 1'b0;
      out_nd   <= 1'b0;
      error    <= 1'b0;
    end else begin
      out_nd <= pop0 || pop1;
      if (pop0) begin
        out_data <= head0[WIDTH-1:0];
        out_m    <= head0[FW-1:WIDTH];
        out_src  <= 1'b0;
        last     <= 1'b0;
      end else if (pop1) begin
        out_data <= head1[WIDTH-1:0];
        out_m    <= head1[FW-1:WIDTH];
        out_src  <= 1'b1;
        last     <= 1'b1;
      end
      if (drop0 || drop1) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nd_stream_arbiter.sv
// Bench for nd_stream_arbiter (DEPTH = 4): directed scenarios plus random
// traffic, every cycle compared against a queue-based reference model.
module tb_nd_stream_arbiter;

  localparam int W = 32;
  localparam int M = 1;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] in0_data, in1_data;
  logic         in0_nd, in1_nd;
  logic [M-1:0] in0_m, in1_m;
  logic [W-1:0] out_data;
  logic         out_nd;
  logic [M-1:0] out_m;
  logic         out_src;
  logic         error;

  nd_stream_arbiter #(.WIDTH(W), .MWIDTH(M), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .in0_data (in0_data),
    .in0_nd   (in0_nd),
    .in0_m    (in0_m),
    .in1_data (in1_data),
    .in1_nd   (in1_nd),
    .in1_m    (in1_m),
    .out_data (out_data),
    .out_nd   (out_nd),
    .out_m    (out_m),
    .out_src  (out_src),
    .error    (error)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int src1_cnt = 0;

  logic [W+M-1:0] exp_q0[$];
  logic [W+M-1:0] exp_q1[$];
  int             m_last = 1;
  logic [W-1:0]   exp_data = '0;
  logic [M-1:0]   exp_m = '0;
  logic           exp_src = 1'b0;
  logic           exp_nd = 1'b0;
  logic           exp_err = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic r,
                      input logic n0, input logic [W-1:0] d0, input logic [M-1:0] mm0,
                      input logic n1, input logic [W-1:0] d1, input logic [M-1:0] mm1);
    logic [W+M-1:0] w;
    bit took0, took1;
    @(negedge clk);
    rst = r;
    in0_nd = n0; in0_data = d0; in0_m = mm0;
    in1_nd = n1; in1_data = d1; in1_m = mm1;
    if (r) begin
      exp_q0.delete();
      exp_q1.delete();
      m_last = 1;
      exp_data = '0; exp_m = '0; exp_src = 1'b0; exp_nd = 1'b0; exp_err = 1'b0;
    end else begin
      took0 = 0;
      took1 = 0;
      if (exp_q0.size() > 0 && exp_q1.size() > 0) begin
        if (m_last == 1) took0 = 1; else took1 = 1;
      end else if (exp_q0.size() > 0) took0 = 1;
      else if (exp_q1.size() > 0) took1 = 1;
      exp_nd = took0 | took1;
      if (took0) begin
        w = exp_q0.pop_front();
        exp_data = w[W-1:0]; exp_m = w[W+M-1:W]; exp_src = 1'b0; m_last = 0;
      end else if (took1) begin
        w = exp_q1.pop_front();
        exp_data = w[W-1:0]; exp_m = w[W+M-1:W]; exp_src = 1'b1; m_last = 1;
      end
      // A word is kept when there is room after this cycle's pop.
      if (n0) begin
        if (exp_q0.size() < D) exp_q0.push_back({mm0, d0}); else exp_err = 1'b1;
      end
      if (n1) begin
        if (exp_q1.size() < D) exp_q1.push_back({mm1, d1}); else exp_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_eq("out_nd", 64'(out_nd), 64'(exp_nd));
    check_eq("out_data", 64'(out_data), 64'(exp_data));
    check_eq("out_m", 64'(out_m), 64'(exp_m));
    check_eq("out_src", 64'(out_src), 64'(exp_src));
    check_eq("error", 64'(error), 64'(exp_err));
    if (out_nd === 1'b1 && out_src === 1'b1) src1_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    in0_nd = 1'b0; in0_data = '0; in0_m = '0;
    in1_nd = 1'b0; in1_data = '0; in1_m = '0;

    do_reset();
    check_eq("reset_nd", 64'(out_nd), 64'd0);
    check_eq("reset_err", 64'(error), 64'd0);
    check_eq("reset_data", 64'(out_data), 64'd0);

    // Single word: visible two cycles after the strobe.
    idle(1);
    step(1'b0, 1'b1, 32'h1234, 1'b1, 1'b0, '0, '0);
    check_eq("single_k1_nd", 64'(out_nd), 64'd0);
    idle(1);
    check_eq("single_nd", 64'(out_nd), 64'd1);
    check_eq("single_data", 64'(out_data), 64'h1234);
    check_eq("single_m", 64'(out_m), 64'd1);
    check_eq("single_src", 64'(out_src), 64'd0);
    idle(1);
    check_eq("single_once", 64'(out_nd), 64'd0);
    check_eq("single_hold", 64'(out_data), 64'h1234);

    // Simultaneous first words after reset: source 0 first.
    do_reset();
    step(1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 32'hB, 1'b1);
    idle(1);
    check_eq("simul_a", 64'(out_data), 64'hA);
    check_eq("simul_a_src", 64'(out_src), 64'd0);
    idle(1);
    check_eq("simul_b", 64'(out_data), 64'hB);
    check_eq("simul_b_src", 64'(out_src), 64'd1);
    idle(2);

    // Contention: both ramps every cycle overflow a DEPTH-4 FIFO.
    do_reset();
    for (int i = 0; i < 2 * D + 2; i++)
      step(1'b0, 1'b1, 32'(i), 1'b0, 1'b1, 32'(100 + i), 1'b1);
    check_eq("contend_err", 64'(error), 64'd1);
    for (int i = 2 * D + 2; i < 3 * D + 4; i++)
      step(1'b0, 1'b1, 32'(i), 1'b0, 1'b1, 32'(100 + i), 1'b1);
    idle(2 * D + 2);
    check_eq("contend_sticky", 64'(error), 64'd1);

    // Full-FIFO boundary: FIFO 1 reaches DEPTH, then push while popped.
    do_reset();
    src1_cnt = 0;
    for (int i = 0; i < 7; i++)
      step(1'b0, (i < 4), 32'(i), 1'b0, 1'b1, 32'(200 + i), 1'b0);
    idle(2 * D + 2);
    check_eq("full_err", 64'(error), 64'd0);
    check_eq("full_src1_count", 64'(src1_cnt), 64'd7);

    // Reset mid-stream with words buffered.
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'(300 + i), 1'b1, 1'b1, 32'(400 + i), 1'b0);
    step(1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b1, 32'hBEEF, 1'b1);
    check_eq("mid_rst_nd", 64'(out_nd), 64'd0);
    check_eq("mid_rst_data", 64'(out_data), 64'd0);
    check_eq("mid_rst_src", 64'(out_src), 64'd0);
    idle(1);
    check_eq("mid_rst_first_nd", 64'(out_nd), 64'd0);
    idle(3);
    step(1'b0, 1'b1, 32'h55, 1'b0, 1'b0, '0, '0);
    idle(1);
    check_eq("mid_rst_lat_nd", 64'(out_nd), 64'd1);
    check_eq("mid_rst_lat_data", 64'(out_data), 64'h55);

    // Source 1 only, nd every cycle.
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b0, '0, '0, 1'b1, 32'(500 + i), M'(i));
    check_eq("src1_nd", 64'(out_nd), 64'd1);
    check_eq("src1_src", 64'(out_src), 64'd1);
    check_eq("src1_err", 64'(error), 64'd0);
    idle(2);

    // Random traffic with varying load and occasional resets.
    do_reset();
    for (int seg = 0; seg < 15; seg++) begin
      int r0, r1;
      r0 = $urandom_range(0, 100);
      r1 = $urandom_range(0, 100);
      for (int i = 0; i < 100; i++) begin
        step(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 99) < r0), $urandom, M'($urandom),
             ($urandom_range(0, 99) < r1), $urandom, M'($urandom));
      end
    end
    idle(2 * D + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
